// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed big-endian data memory for the Y86-64 memory
// stage. Requests and responses use a valid/ready handshake, the response
// latency is set by READ_LAT, and bounds and alignment errors are reported
// per response and in a sticky flag.
module data_mem_ctrl #(
  parameter int unsigned MEM_BYTES   = 1048576,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned ALIGN_CHECK = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        dmem_error
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      mem [MEM_BYTES];

  logic [3:0]      nbytes_c;
  logic [64:0]     last_addr_c;
  logic            err_c;
  logic            accept_c;
  logic [63:0]     rdata_c;
  logic [63:0]     wdata_al_c;
  logic [AW-1:0]   base_c;

  // Decode the request: size, error checks, and the big-endian read value
  always_comb begin
    nbytes_c    = 4'd1 << req_size;
    last_addr_c = {1'b0, req_addr} + 65'(nbytes_c) - 65'd1;
    err_c       = last_addr_c > 65'(MEM_BYTES - 1);
    if (ALIGN_CHECK != 0 && (req_addr & (64'(nbytes_c) - 64'd1)) != 64'd0)
      err_c = 1'b1;
    accept_c    = (state == IDLE) && req_valid && !reset;
    base_c      = req_addr[AW-1:0];
    // Left-justify the used bytes so byte A always comes from bits [63:56]
    wdata_al_c  = req_wdata << (7'd64 - 7'({nbytes_c, 3'b000}));
    rdata_c     = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes_c)
        rdata_c = {rdata_c[55:0], mem[base_c + AW'(i)]};
    end
  end

  // Commit write bytes at the acceptance edge; memory itself is never reset
  always_ff @(posedge clk) begin
    if (accept_c && req_we && !err_c) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nbytes_c)
          mem[base_c + AW'(i)] <= wdata_al_c[8*(7-i) +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 64'd0;
      rsp_err    <= 1'b0;
      dmem_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_rdata <= (err_c || req_we) ? 64'd0 : rdata_c;
            rsp_err   <= err_c;
            req_ready <= 1'b0;
            if (READ_LAT <= 1) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              dmem_error <= dmem_error | err_c;
            end else begin
              state <= BUSY;
              cnt   <= CW'(READ_LAT - 1);
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            dmem_error <= dmem_error | rsp_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances cover READ_LAT=1 without
// alignment checks, READ_LAT=1 with alignment checks, and READ_LAT=3.
module tb_data_mem_ctrl;

  localparam int unsigned MB0 = 1048576;
  localparam int unsigned MBS = 4096;

  logic        clk = 1'b0;
  logic        rst  [3];
  logic        rv   [3];
  logic        rwe  [3];
  logic [1:0]  rsz  [3];
  logic [63:0] ra   [3];
  logic [63:0] rwd  [3];
  logic        rr   [3];
  logic        rrdy [3];
  logic        rspv [3];
  logic [63:0] rd   [3];
  logic        re   [3];
  logic        derr [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.MEM_BYTES(MB0), .READ_LAT(1), .ALIGN_CHECK(0)) u0 (
    .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rrdy[0]),
    .req_we(rwe[0]), .req_size(rsz[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
    .rsp_valid(rspv[0]), .rsp_ready(rr[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]),
    .dmem_error(derr[0]));

  data_mem_ctrl #(.MEM_BYTES(MBS), .READ_LAT(1), .ALIGN_CHECK(1)) u1 (
    .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rrdy[1]),
    .req_we(rwe[1]), .req_size(rsz[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
    .rsp_valid(rspv[1]), .rsp_ready(rr[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]),
    .dmem_error(derr[1]));

  data_mem_ctrl #(.MEM_BYTES(MBS), .READ_LAT(3), .ALIGN_CHECK(0)) u2 (
    .clk(clk), .reset(rst[2]), .req_valid(rv[2]), .req_ready(rrdy[2]),
    .req_we(rwe[2]), .req_size(rsz[2]), .req_addr(ra[2]), .req_wdata(rwd[2]),
    .rsp_valid(rspv[2]), .rsp_ready(rr[2]), .rsp_rdata(rd[2]), .rsp_err(re[2]),
    .dmem_error(derr[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response; leaves it pending
  task automatic issue(input int d, input logic we, input logic [1:0] sz,
                       input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rdat, output logic err, output int lat);
    @(negedge clk);
    check("req_ready_idle", 64'(rrdy[d]), 64'd1);
    rv[d] = 1'b1; rwe[d] = we; rsz[d] = sz; ra[d] = a; rwd[d] = wd;
    @(posedge clk);
    #1 rv[d] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rspv[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) check("rsp_timeout", 64'd1, 64'd0);
    rdat = rd[d];
    err  = re[d];
  endtask

  // Complete the pending response handshake
  task automatic finish_rsp(input int d);
    rr[d] = 1'b1;
    @(posedge clk);
    #1 rr[d] = 1'b0;
  endtask

  // Full access: issue, check data/err/latency, complete the handshake
  task automatic access(input int d, input logic we, input logic [1:0] sz,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] exp_d, input logic exp_e,
                        input int exp_lat, input string tag);
    logic [63:0] rdat;
    logic        err;
    int          lat;
    issue(d, we, sz, a, wd, rdat, err, lat);
    check({tag, "_rdata"}, rdat, exp_d);
    check({tag, "_err"}, 64'(err), 64'(exp_e));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    finish_rsp(d);
  endtask

  initial begin
    logic [63:0] rdat;
    logic        err;
    int          lat;
    logic        seen;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; rv[i] = 1'b0; rwe[i] = 1'b0; rsz[i] = 2'd0;
      ra[i] = 64'd0; rwd[i] = 64'd0; rr[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);

    // Reset values
    for (int i = 0; i < 3; i += 2) begin
      check("rst_req_ready", 64'(rrdy[i]), 64'd1);
      check("rst_rsp_valid", 64'(rspv[i]), 64'd0);
      check("rst_rdata", rd[i], 64'd0);
      check("rst_err", 64'(re[i]), 64'd0);
      check("rst_dmem_error", 64'(derr[i]), 64'd0);
    end

    // READ_LAT=1 basic big-endian accesses
    access(0, 1'b1, 2'd3, 64'h100, 64'h0123456789ABCDEF, 64'd0, 1'b0, 1, "w8_100");
    access(0, 1'b0, 2'd3, 64'h100, 64'd0, 64'h0123456789ABCDEF, 1'b0, 1, "r8_100");
    access(0, 1'b0, 2'd0, 64'h100, 64'd0, 64'h01, 1'b0, 1, "r1_100");
    access(0, 1'b0, 2'd0, 64'h107, 64'd0, 64'hEF, 1'b0, 1, "r1_107");
    access(0, 1'b1, 2'd1, 64'h102, 64'hFFFF_FFFF_FFFF_BEEF, 64'd0, 1'b0, 1, "w2_102");
    access(0, 1'b0, 2'd3, 64'h100, 64'd0, 64'h0123BEEF89ABCDEF, 1'b0, 1, "r8_merge");
    access(0, 1'b0, 2'd1, 64'h103, 64'd0, 64'hEF89, 1'b0, 1, "r2_103");
    access(0, 1'b0, 2'd2, 64'h104, 64'd0, 64'h89ABCDEF, 1'b0, 1, "r4_104");

    // Bounds
    access(0, 1'b1, 2'd3, 64'(MB0 - 8), 64'h1122334455667788, 64'd0, 1'b0, 1, "w8_top");
    access(0, 1'b0, 2'd3, 64'(MB0 - 8), 64'd0, 64'h1122334455667788, 1'b0, 1, "r8_top");
    access(0, 1'b0, 2'd0, 64'(MB0 - 1), 64'd0, 64'h88, 1'b0, 1, "r1_last");
    check("dmem_clean", 64'(derr[0]), 64'd0);
    issue(0, 1'b0, 2'd3, 64'(MB0 - 7), 64'd0, rdat, err, lat);
    check("r8_over_rdata", rdat, 64'd0);
    check("r8_over_err", 64'(err), 64'd1);
    check("r8_over_dmem", 64'(derr[0]), 64'd1);
    finish_rsp(0);
    access(0, 1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEADDEADDEADDEAD, 64'd0, 1'b1, 1, "w8_wrap");
    access(0, 1'b0, 2'd3, 64'(MB0 - 8), 64'd0, 64'h1122334455667788, 1'b0, 1, "r8_top_kept");
    check("dmem_sticky", 64'(derr[0]), 64'd1);

    // Alignment checking
    access(1, 1'b1, 2'd2, 64'h100, 64'hAABBCCDD, 64'd0, 1'b0, 1, "a_w4_100");
    access(1, 1'b1, 2'd2, 64'h102, 64'h11111111, 64'd0, 1'b1, 1, "a_w4_102");
    access(1, 1'b1, 2'd2, 64'h104, 64'h01020304, 64'd0, 1'b0, 1, "a_w4_104");
    access(1, 1'b0, 2'd3, 64'h100, 64'd0, 64'hAABBCCDD01020304, 1'b0, 1, "a_r8_100");
    access(1, 1'b0, 2'd1, 64'h101, 64'd0, 64'd0, 1'b1, 1, "a_r2_101");
    check("a_dmem", 64'(derr[1]), 64'd1);

    // READ_LAT=3 with backpressure
    access(2, 1'b1, 2'd3, 64'h40, 64'h0F1E2D3C4B5A6978, 64'd0, 1'b0, 3, "l3_w8");
    issue(2, 1'b0, 2'd3, 64'h40, 64'd0, rdat, err, lat);
    check("l3_lat", 64'(lat), 64'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 64'(rspv[2]), 64'd1);
      check("bp_rdata", rd[2], 64'h0F1E2D3C4B5A6978);
      check("bp_err", 64'(re[2]), 64'd0);
      check("bp_req_ready", 64'(rrdy[2]), 64'd0);
    end
    finish_rsp(2);
    check("bp_rel_valid", 64'(rspv[2]), 64'd0);
    check("bp_rel_ready", 64'(rrdy[2]), 64'd1);

    // Make dmem_error set so the reset clearing it is observable
    access(2, 1'b0, 2'd3, 64'(MBS - 6), 64'd0, 64'd0, 1'b1, 3, "l3_over");
    check("l3_dmem", 64'(derr[2]), 64'd1);

    // Reset while a write is in BUSY
    @(negedge clk);
    rv[2] = 1'b1; rwe[2] = 1'b1; rsz[2] = 2'd3; ra[2] = 64'h80;
    rwd[2] = 64'hCAFEF00DDEADBEEF;
    @(posedge clk);
    #1 rv[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    check("mid_rst_valid", 64'(rspv[2]), 64'd0);
    check("mid_rst_ready", 64'(rrdy[2]), 64'd1);
    check("mid_rst_dmem", 64'(derr[2]), 64'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rspv[2]) seen = 1'b1;
    end
    check("no_rsp_after_rst", 64'(seen), 64'd0);
    access(2, 1'b0, 2'd3, 64'h80, 64'd0, 64'hCAFEF00DDEADBEEF, 1'b0, 3, "post_rst_r8");
    access(2, 1'b0, 2'd2, 64'h44, 64'd0, 64'h4B5A6978, 1'b0, 3, "post_rst_r4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
